// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler and future LED/7-seg arbiters.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } led_state_e;

  localparam int TICK_DIV_DEFAULT = 25000000;
  localparam int MAX_REQ          = 8;

  // First set bit of vec[n-1:0], searching upward from ptr with wrap; 0 if none set.
  function automatic logic [2:0] ffs_from(input logic [MAX_REQ-1:0] vec,
                                          input logic [2:0]         ptr,
                                          input int                 n);
    logic [2:0] res;
    int         k;
    res = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (vec[k[2:0]]) res = k[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink prescaler: counts 0..TICK_DIV-1, pulses tick on the last count, clr realigns to 0.
module led_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin LED bank arbiter and blink sequencer.
// Define LED_SCHED_PRIO_EN for fixed lowest-index-wins priority (no rr_ptr).
//
// state | meaning
// IDLE  | bank free, waiting for any request
// ON    | granted pattern driven on led
// OFF   | led dark, second half of a blink period
// DONE  | one-cycle completion pulse on done[sel]
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int N_REQ    = 4,
  parameter int LED_W    = 8,
  parameter int DUR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] req_pat,
  input  logic [N_REQ*DUR_W-1:0] req_dur,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [LED_W-1:0]       led,
  output logic                   busy
);

  led_state_e        state, state_nxt;
  logic [2:0]        sel, sel_nxt;
  logic [2:0]        ptr, pick, pick_inc;
  logic [LED_W-1:0]  pat_q, pat_nxt;
  logic [DUR_W-1:0]  rem_q, rem_nxt;
  logic [N_REQ-1:0]  gnt_nxt, done_nxt;
  logic [LED_W-1:0]  led_nxt;
  logic              busy_nxt;
  logic              tick, clr;
  logic [7:0]        req_ext, pick_oh, sel_oh;
  logic [LED_W-1:0]  pick_pat;
  logic [DUR_W-1:0]  pick_dur;

  assign req_ext  = 8'(req);
  assign pick     = ffs_from(req_ext, ptr, N_REQ);
  assign pick_inc = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
  assign pick_oh  = 8'd1 << pick;
  assign sel_oh   = 8'd1 << sel;
  assign pick_pat = req_pat[int'(pick)*LED_W +: LED_W];
  assign pick_dur = req_dur[int'(pick)*DUR_W +: DUR_W];

`ifdef LED_SCHED_PRIO_EN
  assign ptr = 3'd0;
`else
  logic [2:0] rr_ptr, rr_nxt;
  assign ptr = rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_nxt;
  end
`endif

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      pat_q <= '0;
      rem_q <= '0;
      gnt   <= '0;
      done  <= '0;
      led   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      pat_q <= pat_nxt;
      rem_q <= rem_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      led   <= led_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pat_nxt   = pat_q;
    rem_nxt   = rem_q;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    led_nxt   = led;
    busy_nxt  = busy;
    clr       = 1'b0;
`ifndef LED_SCHED_PRIO_EN
    rr_nxt    = rr_ptr;
`endif
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        led_nxt  = '0;
        busy_nxt = 1'b0;
        if (|req) begin
          state_nxt = ON;
          sel_nxt   = pick;
          pat_nxt   = pick_pat;
          rem_nxt   = (pick_dur == '0) ? DUR_W'(1) : pick_dur;
          gnt_nxt   = pick_oh[N_REQ-1:0];
          led_nxt   = pick_pat;
          busy_nxt  = 1'b1;
          clr       = 1'b1;
`ifndef LED_SCHED_PRIO_EN
          rr_nxt    = pick_inc;
`endif
        end
      end
      ON, OFF: begin
        // Abort has priority over a coincident tick.
        if (!req_ext[sel]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          led_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (tick) begin
          if (state == ON) begin
            state_nxt = OFF;
            led_nxt   = '0;
          end else if (rem_q == DUR_W'(1)) begin
            state_nxt = DONE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = sel_oh[N_REQ-1:0];
          end else begin
            state_nxt = ON;
            rem_nxt   = rem_q - 1'b1;
            led_nxt   = pat_q;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched: show-level timing model feeds a per-cycle expectation queue.
module tb_led_blink_sched;

  localparam int T  = 4;
  localparam int N  = 4;
  localparam int LW = 8;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_pat;
  logic [N*DW-1:0] req_dur;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [LW-1:0]   led;
  logic            busy;

  led_blink_sched #(.TICK_DIV(T), .N_REQ(N), .LED_W(LW), .DUR_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_pat (req_pat),
    .req_dur (req_dur),
    .gnt     (gnt),
    .done    (done),
    .led     (led),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [LW-1:0] led;
    logic [N-1:0]  done;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: a show is (sel, pat, n, elapsed cycles since grant).
  int          m_sel = 0;
  int          m_rr = 0;
  int          m_el = 0;
  int          m_n = 1;
  bit          m_active = 0;
  bit          m_done_ph = 0;
  logic [7:0]  m_pat = '0;

  initial begin
    forever begin
      exp_t e;
      int   d;
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_active = 0; m_done_ph = 0; m_rr = 0;
      end else if (m_done_ph) begin
        m_done_ph = 0;
      end else if (m_active) begin
        if (!req[m_sel]) m_active = 0;
        else begin
          m_el++;
          if (m_el == 2 * m_n * T) begin
            m_active = 0; m_done_ph = 1;
          end
        end
      end else if (req != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_rr + k) % N]) m_sel = (m_rr + k) % N;
        m_active = 1;
        m_el     = 0;
        m_pat    = req_pat[m_sel*LW +: LW];
        d        = int'(req_dur[m_sel*DW +: DW]);
        m_n      = (d == 0) ? 1 : d;
`ifndef LED_SCHED_PRIO_EN
        m_rr     = (m_sel + 1) % N;
`endif
      end
      if (m_active) begin
        e.gnt  = N'(1 << m_sel);
        e.busy = 1'b1;
        e.led  = ((m_el / T) % 2 == 0) ? m_pat : 8'h00;
      end else if (m_done_ph) begin
        e.done = N'(1 << m_sel);
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: compares on every falling clock edge, and right after an async reset assertion.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk or negedge rst_n);
      #1;
      if (clk == 1'b1 && !rst_n) begin
        exp_q.delete();
        exp_q.push_back('0);
        chk("rst_gnt",  int'(gnt),  0);
        chk("rst_led",  int'(led),  0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",  int'(gnt),  int'(e.gnt));
        chk("led",  int'(led),  int'(e.led));
        chk("done", int'(done), int'(e.done));
        chk("busy", int'(busy), int'(e.busy));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    req = '0;
    step(12);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_pat = '0; req_dur = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // single request
    req_pat = 32'h0000_00A5; req_dur = 32'h0000_0002; req = 4'b0001;
    step(20);
    go_idle();

    // round-robin with all requesters pending
    req_pat = 32'h4433_2211; req_dur = 32'h0101_0101; req = 4'b1111;
    step(5 * (2 * T + 2) + 5);
    go_idle();

    // zero duration
    req_pat = 32'h0000_5A00; req_dur = 32'h0000_0000; req = 4'b0010;
    step(15);
    go_idle();

    // abort two cycles into ON, other request pending
    req_pat = 32'h7700_3300; req_dur = 32'h0303_0303; req = 4'b0101;
    step(3);
    req[m_sel] = 1'b0;
    step(40);
    go_idle();

    // pattern change mid-show
    req_pat = 32'hC300_0000; req_dur = 32'h0200_0000; req = 4'b1000;
    step(6);
    req_pat = $urandom;
    step(12);
    req_pat = $urandom;
    step(12);
    go_idle();

    // reset during OFF
    req_pat = 32'h0000_00F0; req_dur = 32'h0000_0003; req = 4'b0001;
    step(T + 2);
    rst_n = 1'b0;
    step(2);
    req = 4'b1111;
    rst_n = 1'b1;
    step(30);
    go_idle();

    // randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      req_pat = $urandom;
      for (int i = 0; i < N; i++) req_dur[i*DW +: DW] = DW'($urandom_range(0, 3));
      req = N'($urandom_range(0, 15));
      step($urandom_range(3, 20));
      if ($urandom_range(0, 3) == 0) req_pat = $urandom;
      step($urandom_range(3, 30));
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_blink_sched.md
# led_blink_sched

Arbiter and sequencer for the board LED bank. Up to N_REQ requesters each ask to show an LED pattern for a given number of blink periods. The block grants the bank to one requester at a time, round-robin, and blinks that requester's pattern on/off from an internal tick prescaler. When the blink count is exhausted it releases the bank. It sits between application logic and the physical LED pins.

## Interface
Parameters:
- TICK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); minimum 2
- N_REQ, 4, number of requesters; 2..8
- LED_W, 8, LED bank width
- DUR_W, 8, blink-count width

Ports:
- clk  in  1  system clock (one clock domain)
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  level request, one bit per requester
- req_pat  in  N_REQ*LED_W  pattern of requester i at [i*LED_W +: LED_W]
- req_dur  in  N_REQ*DUR_W  blink count of requester i at [i*DUR_W +: DUR_W]; 0 treated as 1
- gnt  out  N_REQ  one-hot grant, registered
- done  out  N_REQ  one-cycle completion pulse for the granted requester
- led  out  LED_W  LED drive, registered
- busy  out  1  high whenever a grant is held

## Operation
- States: IDLE, ON, OFF, DONE.
- Tick prescaler:
  - counter runs 0..TICK_DIV-1; tick is a one-cycle pulse when it equals TICK_DIV-1, then it wraps to 0.
  - The counter clears to 0 on every new grant, so phases are aligned to the grant.
- IDLE: led=0, gnt=0.
  - If any req bit is set, select the first set bit searching from rr_ptr upward with wrap.
  - Latch its pattern and duration, and load remaining = max(dur,1).
  - Set gnt, busy, rr_ptr = (sel+1) mod N_REQ. Go to ON.
- ON: led = latched pattern. On tick, go to OFF.
- OFF: led=0. On tick:
  - if remaining==1, go to DONE;
  - otherwise decrement remaining and go to ON.
- DONE: lasts one cycle. gnt=0, busy=0, done[sel]=1, led=0. Go to IDLE.
- Abort: if req[sel] falls while in ON or OFF, go to IDLE on the next edge.
  - led, gnt and busy clear; no done pulse.
- Latched pattern and duration are not re-sampled during a show. Changes to req_pat or req_dur mid-show are ignored.
- Requests other than req[sel] are ignored until IDLE.

## Timing
- Reset values: led=0, gnt=0, done=0, busy=0, state=IDLE, rr_ptr=0, prescaler=0, remaining=0.
- Reset asserted mid-show clears everything immediately, with no done pulse.
- Latency: req sampled in IDLE at edge k; gnt, busy and the pattern on led are visible after edge k+1.
- ON and OFF each last exactly TICK_DIV cycles.
- A full show lasts 2*max(dur,1)*TICK_DIV cycles, then one DONE cycle.
- Back-to-back shows: the earliest new grant occurs 2 cycles after the DONE cycle begins (DONE, then the IDLE sampling cycle).
- Simultaneous requests in IDLE resolve in the same cycle by round-robin order. rr_ptr advances only on a grant.
- Abort and tick in the same cycle: abort wins.

## Configuration
- LED_SCHED_PRIO_EN:
  - Defined: fixed priority, lowest index wins; rr_ptr is not implemented.
  - Undefined (default): round-robin as described above.

## Structure
- Package led_sched_pkg holds:
  - the state enum (IDLE, ON, OFF, DONE);
  - the default TICK_DIV constant;
  - a find-first-set-from-pointer function, shared with future LED/7-seg arbiters.
- Sub-module led_tick_gen: prescaler with clear input and tick output.
- Arbitration and FSM live in the top module.

## Test plan
All scenarios use TICK_DIV=4, N_REQ=4, LED_W=8.
- Single request: req=0001, pat0=0xA5, dur0=2.
  - gnt=0001 one cycle later; led = 0xA5 for 4 cycles, 0 for 4, 0xA5 for 4, 0 for 4.
  - Then done=0001 for one cycle and gnt=0.
- Round-robin: req=1111 held, all dur=1.
  - Grants occur in order 0001, 0010, 0100, 1000, 0001.
  - With LED_SCHED_PRIO_EN defined: always 0001.
- Zero duration: dur=0 behaves as dur=1 (one on/off pair, then done).
- Abort: drop req[sel] 2 cycles into ON.
  - led=0 and gnt=0 on the next edge; no done pulse; other pending requests are granted afterwards.
- Reset mid-show: pull rst_n low during OFF.
  - All outputs are 0 immediately; after release, the first grant goes to requester 0.
- Pattern change: alter req_pat of the granted requester mid-show.
  - led keeps showing the latched pattern.
